// File: rtl/kbd_scanfifo.sv
// PS/2 set-2 scancode folder: collapses E0/F0/E1 prefix runs into single key
// events and queues them in a show-ahead FIFO that the CPU drains with rd.
module kbd_scanfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            ps2_data,
  input  logic                  ps2_hit,
  input  logic                  rd,
  input  logic                  clr,
  output logic [7:0]            q_code,
  output logic                  q_extended,
  output logic                  q_release,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  typedef enum logic {IDLE, SKIP} state_e;

  // [0]=s1, [1]=s2, [2]=s3; ps2_hit may be asynchronous to clock
  logic [2:0] hit_pipe_q, hit_pipe_d;
  logic       byte_evt;

  state_e               state_q, state_d;
  logic                 ext_pend_q, ext_pend_d;
  logic                 rel_pend_q, rel_pend_d;
  logic [2:0]           skip_cnt_q, skip_cnt_d;
  logic                 ev_vld;
  ev_t                  ev;

  ev_t                  mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  ev_t                  head_q, head_d;
  logic                 full, pop, push_req, push_ok;

  assign hit_pipe_d = {hit_pipe_q[1:0], ps2_hit};
  assign byte_evt   = hit_pipe_q[1] & ~hit_pipe_q[2];

  always_comb begin
    state_d    = state_q;
    ext_pend_d = ext_pend_q;
    rel_pend_d = rel_pend_q;
    skip_cnt_d = skip_cnt_q;
    ev_vld     = 1'b0;
    ev         = '{rel: rel_pend_q, ext: ext_pend_q, code: ps2_data};
    if (byte_evt) begin
      case (state_q)
        IDLE: begin
          if (ps2_data == 8'hE0) ext_pend_d = 1'b1;
          else if (ps2_data == 8'hF0) rel_pend_d = 1'b1;
          else if (ps2_data == 8'hE1) begin
            state_d    = SKIP;
            skip_cnt_d = 3'd6;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end else if (!(ext_pend_q || rel_pend_q) &&
                       (ps2_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            ev_vld = 1'b0;
          end else begin
            ev_vld     = 1'b1;
            ext_pend_d = 1'b0;
            rel_pend_d = 1'b0;
          end
        end
        SKIP: begin
          // Pause is E1 plus seven bytes; the last one becomes the event
          if (skip_cnt_q == 3'd0) begin
            ev_vld  = 1'b1;
            ev      = '{rel: 1'b0, ext: 1'b1, code: 8'hE1};
            state_d = IDLE;
          end else begin
            skip_cnt_d = skip_cnt_q - 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (clr) begin
      state_d    = IDLE;
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
      skip_cnt_d = 3'd0;
    end
  end

  always_comb begin
    full       = (count_q == CNT_FULL);
    push_req   = ev_vld & ~clr;
    pop        = rd & (count_q != '0) & ~clr;
    push_ok    = push_req & (~full | pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & full & ~pop);
    head_d     = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push_ok) count_d = count_q - CNT_ONE;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
    // Head register mirrors mem[rd_ptr]; holds its last value once drained
    if (count_d != '0)
      head_d = (push_ok && rd_ptr_d == wr_ptr_q) ? ev : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_pipe_q <= '0;
      state_q    <= IDLE;
      ext_pend_q <= 1'b0;
      rel_pend_q <= 1'b0;
      skip_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      hit_pipe_q <= hit_pipe_d;
      state_q    <= state_d;
      ext_pend_q <= ext_pend_d;
      rel_pend_q <= rel_pend_d;
      skip_cnt_q <= skip_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= ev;
  end

  assign q_code     = head_q.code;
  assign q_extended = head_q.ext;
  assign q_release  = head_q.rel;
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_scanfifo.sv
// Directed + randomized bench for kbd_scanfifo against a queue-based model of
// the prefix-folding rules.
module tb_kbd_scanfifo;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    ps2_data = 8'h00;
  logic          ps2_hit = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [7:0]    q_code;
  logic          q_extended, q_release, empty, overflow;
  logic [DL:0]   count;

  kbd_scanfifo #(.DEPTH_LOG2(DL)) dut (
    .clock(clk), .reset_n(reset_n), .ps2_data(ps2_data), .ps2_hit(ps2_hit),
    .rd(rd), .clr(clr), .q_code(q_code), .q_extended(q_extended),
    .q_release(q_release), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Model: queue of {rel, ext, code}
  logic [9:0] mq[$];
  logic       m_ovf, m_ext, m_rel;
  int         m_pause;
  logic [9:0] m_head;
  logic [7:0] fill_tbl [6] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".code"},  32'(q_code), 32'(m_head[7:0]));
    chk({tag, ".ext"},   32'(q_extended), 32'(m_head[8]));
    chk({tag, ".rel"},   32'(q_release), 32'(m_head[9]));
  endtask

  task automatic m_clr();
    mq.delete(); m_ovf = 0; m_ext = 0; m_rel = 0; m_pause = 0;
  endtask

  task automatic m_push(input logic [9:0] e);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(e);
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) m_push({1'b0, 1'b1, 8'hE1});
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE1) begin m_pause = 7; m_ext = 0; m_rel = 0; end
    else if (!m_ext && !m_rel && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) ;
    else begin m_push({m_rel, m_ext, b}); m_ext = 0; m_rel = 0; end
  endtask

  task automatic m_refresh();
    if (mq.size() > 0) m_head = mq[0];
  endtask

  // Byte strobe: hit high for two edges; rd/clr optionally coincide with the push edge
  task automatic send(input logic [7:0] b, input logic do_rd, input logic do_clr);
    @(negedge clk); ps2_data = b; ps2_hit = 1'b1;
    @(negedge clk);
    @(negedge clk); ps2_hit = 1'b0; rd = do_rd; clr = do_clr;
    @(negedge clk); rd = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    if (do_clr) m_clr();
    else begin
      if (do_rd && mq.size() > 0) void'(mq.pop_front());
      m_byte(b);
    end
    m_refresh();
  endtask

  task automatic pop_one();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    m_refresh();
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_clr(); m_refresh();
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    case ($urandom_range(0, 7))
      0: b = 8'hE0;
      1: b = 8'hF0;
      2: b = fill_tbl[$urandom_range(0, 5)];
      default: begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE1) b = 8'h5A;
      end
    endcase
    return b;
  endfunction

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    m_clr(); m_head = '0;
    repeat (2) @(negedge clk);
    check_state("reset");
    reset_n = 1'b1;

    // 1: latency of a plain make code
    @(negedge clk); ps2_data = 8'h1C; ps2_hit = 1'b1;
    @(negedge clk); chk("lat.e1_empty", 32'(empty), 32'd1);
    @(negedge clk); ps2_hit = 1'b0; chk("lat.e2_empty", 32'(empty), 32'd1);
    @(negedge clk); chk("lat.e3_empty", 32'(empty), 32'd0);
    chk("lat.e3_count", 32'(count), 32'd1);
    repeat (3) @(negedge clk);
    m_byte(8'h1C); m_refresh();
    check_state("t1");
    pop_one(); check_state("t1.pop");

    // 2: E0 F0 75 then F0 1C
    send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
    chk("t2.ext_rel", {22'd0, q_release, q_extended, q_code}, 32'h375);
    check_state("t2a");
    send(8'hF0, 0, 0); send(8'h1C, 0, 0);
    check_state("t2b");
    pop_one();
    chk("t2.second", {22'd0, q_release, q_extended, q_code}, 32'h21C);
    check_state("t2c");
    pop_one(); check_state("t2d");

    // 3: Pause sequence folds into one event
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i], 0, 0);
      if (i == 6) chk("t3.no_early", 32'(count), 32'd0);
    end
    chk("t3.pause", {22'd0, q_release, q_extended, q_code}, 32'h1E1);
    check_state("t3a");
    send(8'h29, 0, 0); check_state("t3b");
    pop_one(); check_state("t3c");
    chk("t3.plain", {22'd0, q_release, q_extended, q_code}, 32'h029);
    pop_one();

    // 4: overflow on the 17th event
    for (int i = 1; i <= 17; i++) send(8'(i), 0, 0);
    chk("t4.count", 32'(count), 32'd16);
    chk("t4.ovf", 32'(overflow), 32'd1);
    chk("t4.head", 32'(q_code), 32'h01);
    check_state("t4");
    for (int i = 1; i <= 16; i++) begin
      chk("t4.drain", 32'(q_code), 32'(i));
      pop_one();
    end
    check_state("t4.empty");

    // 5: push+pop while full, then clr
    pulse_clr();
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 0, 0);
    send(8'h22, 1, 0);
    chk("t5.count", 32'(count), 32'd16);
    chk("t5.ovf", 32'(overflow), 32'd0);
    check_state("t5a");
    for (int i = 0; i < 16; i++) begin check_state("t5.drain"); pop_one(); end
    chk("t5.tail", 32'(q_code), 32'h22);
    for (int i = 0; i < 17; i++) send(8'h40 + 8'(i), 0, 0);
    check_state("t5.refull");
    pulse_clr();
    chk("t5.clr_count", 32'(count), 32'd0);
    chk("t5.clr_ovf", 32'(overflow), 32'd0);
    check_state("t5.clr");
    send(8'h44, 0, 1); check_state("t5.clr_lost");
    send(8'hE0, 0, 0); pulse_clr(); send(8'h6B, 0, 0);
    chk("t5.clr_prefix", 32'(q_extended), 32'd0);
    check_state("t5.clr_pref");
    pulse_clr();

    // 6: fillers discarded; reset drops pending prefix (async assert)
    send(8'hAA, 0, 0); send(8'hFA, 0, 0);
    check_state("t6.filler");
    send(8'h11, 0, 0); send(8'hE0, 0, 0);
    @(negedge clk); #2 reset_n = 1'b0; #1;
    m_clr(); m_head = '0;
    check_state("t6.async_rst");
    @(negedge clk); reset_n = 1'b1;
    send(8'h6B, 0, 0);
    chk("t6.after_rst", {22'd0, q_release, q_extended, q_code}, 32'h06B);
    check_state("t6");
    pop_one();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 11) send(rand_byte(), ($urandom_range(0, 3) == 0), 1'b0);
      else if (r < 18) pop_one();
      else if (r == 18) pulse_clr();
      else send(rand_byte(), 1'b0, 1'b1);
      check_state("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/kbd_scanfifo.md
Name: kbd_scanfifo

Overview:
Sits between the PS/2 keyboard receiver and the memory controller. It consumes raw set-2 scancode bytes (byte plus strobe) and folds the E0/F0/E1 prefix sequences into single key events. Each event carries a code, an extended flag and a release flag, and is queued in a show-ahead FIFO. The CPU drains the FIFO through memctrl using a read strobe, so keystrokes are not lost while software is busy.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 events).

Ports:
clock  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
ps2_data  input  8  received scancode byte; stable while ps2_hit is high and for ≥4 clock cycles after ps2_hit rises.
ps2_hit  input  1  byte-received strobe; may come from another clock domain; high ≥2 clock cycles.
rd  input  1  pop head event; one pop per cycle it is high.
clr  input  1  synchronous flush.
q_code  output  8  head event scancode.
q_extended  output  1  head event had an E0 prefix (or is a Pause event).
q_release  output  1  head event had an F0 prefix.
empty  output  1  FIFO empty.
count  output  DEPTH_LOG2+1  number of queued events.
overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO pointers=0, count=0, empty=1, overflow=0, q_*=0, prefix flags=0, decoder in IDLE, synchroniser flops=0.
- Strobe synchronisation:
  - ps2_hit passes through flops s1→s2, with s3 as a delayed copy of s2.
  - byte_evt = s2 & ~s3.
  - ps2_data is sampled directly on the clock edge where byte_evt=1.
  - Latency: ps2_hit rises before edge E1; the push occurs at E3; empty falls after E3.
- Decoder FSM (acts only on byte_evt):
  - IDLE:
    - 0xE0 → set ext_pend.
    - 0xF0 → set rel_pend.
    - 0xE1 → go to SKIP with skip_cnt=6.
    - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF with no prefix pending → discarded.
    - Any other byte, or any byte while a prefix is pending → push event {rel_pend, ext_pend, data}, then clear both prefix flags.
  - SKIP: each byte decrements skip_cnt. The 7th byte after E1 (the byte seen at skip_cnt=0) pushes the synthetic event code=0xE1, ext=1, rel=0, and the FSM returns to IDLE.
- FIFO:
  - 2^DEPTH_LOG2 entries of 10 bits.
  - Show-ahead: q_* always shows mem[rd_ptr]. When empty, q_* holds its last value (0 after reset).
  - Pop: rd=1 and not empty → rd_ptr+1. rd while empty is ignored.
  - Push while full without a simultaneous pop → event dropped, overflow←1. Pointers and count unchanged.
  - Push and pop in the same cycle while full → both happen; count stays at full; no overflow.
  - Push and pop in the same cycle while empty → push only; rd ignored.
  - Pointers wrap modulo depth. count tracks (pushes − pops) exactly; it is never > 2^DEPTH_LOG2 and never negative.
- clr:
  - Resets pointers, count, overflow, prefix flags and the FSM to IDLE; synchroniser flops are unchanged.
  - Has priority over push and rd in the same cycle; an event arriving in that cycle is lost.
- Reset mid-sequence (e.g. after E0 F0) discards the pending prefixes; the next plain byte is a normal make event.

Test Plan:
1. Reset; feed 0x1C → after 3 cycles: empty=0, count=1, q_code=0x1C, q_ext=0, q_rel=0. Pulse rd → empty=1, count=0.
2. Feed E0 F0 75 → exactly one event: q_code=0x75, q_ext=1, q_rel=1. Then feed F0 1C → second event 0x1C, q_rel=1, q_ext=0.
3. Feed E1 14 77 E1 F0 14 F0 77 → exactly one event {0xE1, ext=1, rel=0}; a following 0x29 yields a plain 0x29 event.
4. Feed 17 bytes 0x01..0x11 without rd → count=16, overflow=1, head=0x01. Drain all 16 in order 0x01..0x10; 0x11 is absent.
5. With FIFO full, feed 0x22 in the same cycle rd=1 → count stays 16, overflow stays 0; 0x22 becomes the tail. Then pulse clr → count=0, empty=1, overflow=0.
6. Feed 0xAA and 0xFA with no prefix → no events. Feed E0, then assert reset_n low, then feed 0x6B → event 0x6B with ext=0.
